// File: rtl/pcie_rx_pkt_buffer.sv
// pcie_rx_pkt_buffer: store-and-forward PCIe RX packet buffer; whole-packet drop, no input back-pressure.
// Define PCIE_RX_PKT_BUF_LAT_EN to add per-packet buffer latency tracking (lat_last, lat_max).
module pcie_rx_pkt_buffer #(
  parameter int DATA_W    = 256,
  parameter int KEEP_W    = 32,
  parameter int USER_W    = 64,
  parameter int DEPTH     = 512,
  parameter int PKT_DEPTH = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic              RX_clk,
  input  logic              RX_rst,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [31:0]       cnt_pkt_in,
  output logic [31:0]       cnt_pkt_out,
  output logic [31:0]       cnt_pkt_drop
`ifdef PCIE_RX_PKT_BUF_LAT_EN
  ,
  output logic [31:0]       lat_last,
  output logic [31:0]       lat_max
`endif
);
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int DW  = $clog2(PKT_DEPTH);
  localparam int DPW = DW + 1;
  localparam int BW  = $clog2(MAX_BEATS + 1);
  localparam int EW  = DATA_W + KEEP_W + USER_W;

  logic [EW-1:0]  mem [DEPTH];
  logic [BW-1:0]  dsc_cnt [PKT_DEPTH];
  logic [PW-1:0]  wr_spec, wr_commit, rd, raddr;
  logic [DPW-1:0] dsc_wr, dsc_rd, dsc_iss;
  logic [BW-1:0]  beat_cnt, iss_idx;
  logic           dropping, accept, drop_now, drop_end, wr_en, commit;
  logic           issue, iss_last, rv, rl, sk_v, load, pop;
  logic [EW-1:0]  ram_q;
  logic [EW:0]    sk;
  logic [1:0]     occ;

  assign accept   = s_tvalid && s_tready;
  assign drop_now = accept && !dropping && (((wr_spec - rd) == PW'(DEPTH)) ||
                    (beat_cnt >= BW'(MAX_BEATS)) ||
                    (s_tlast && ((dsc_wr - dsc_rd) == DPW'(PKT_DEPTH))));
  assign wr_en    = accept && !dropping && !drop_now;
  assign commit   = wr_en && s_tlast;
  assign drop_end = accept && s_tlast && (dropping || drop_now);

  always_ff @(posedge RX_clk or posedge RX_rst)
    if (RX_rst) begin
      s_tready     <= 1'b0;
      wr_spec      <= '0;
      wr_commit    <= '0;
      dsc_wr       <= '0;
      beat_cnt     <= '0;
      dropping     <= 1'b0;
      cnt_pkt_in   <= '0;
      cnt_pkt_drop <= '0;
    end else begin
      s_tready  <= 1'b1;
      wr_spec   <= drop_now ? wr_commit : wr_en ? wr_spec + PW'(1) : wr_spec;
      wr_commit <= commit ? wr_spec + PW'(1) : wr_commit;
      dsc_wr    <= commit ? dsc_wr + DPW'(1) : dsc_wr;
      beat_cnt  <= (commit || drop_end) ? '0 : wr_en ? beat_cnt + BW'(1) : beat_cnt;
      dropping  <= drop_end ? 1'b0 : dropping || drop_now;
      if (commit) cnt_pkt_in <= cnt_pkt_in + 32'd1;
      if (drop_end) cnt_pkt_drop <= cnt_pkt_drop + 32'd1;
    end

  always_ff @(posedge RX_clk) begin
    if (wr_en) mem[wr_spec[AW-1:0]] <= {s_tdata, s_tkeep, s_tuser};
    if (commit) dsc_cnt[dsc_wr[DW-1:0]] <= beat_cnt + BW'(1);
    if (issue) ram_q <= mem[raddr[AW-1:0]];
  end

  // Prefetch only while output reg + skid + in-flight RAM read stay within two entries.
  assign pop      = m_tvalid && m_tready;
  assign load     = pop || !m_tvalid;
  assign occ      = 2'(m_tvalid) + 2'(sk_v) + 2'(rv);
  assign issue    = (raddr != wr_commit) && ((occ - 2'(pop)) < 2'd2);
  assign iss_last = iss_idx == dsc_cnt[dsc_iss[DW-1:0]];

  always_ff @(posedge RX_clk or posedge RX_rst)
    if (RX_rst) begin
      raddr       <= '0;
      rd          <= '0;
      dsc_iss     <= '0;
      dsc_rd      <= '0;
      iss_idx     <= BW'(1);
      rv          <= 1'b0;
      rl          <= 1'b0;
      sk_v        <= 1'b0;
      sk          <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_tdata     <= '0;
      m_tkeep     <= '0;
      m_tuser     <= '0;
      cnt_pkt_out <= '0;
    end else begin
      raddr    <= issue ? raddr + PW'(1) : raddr;
      iss_idx  <= issue ? (iss_last ? BW'(1) : iss_idx + BW'(1)) : iss_idx;
      dsc_iss  <= (issue && iss_last) ? dsc_iss + DPW'(1) : dsc_iss;
      rv       <= issue;
      rl       <= issue && iss_last;
      rd       <= rd + PW'(pop);
      m_tvalid <= load ? (sk_v || rv) : 1'b1;
      sk_v     <= load ? (sk_v && rv) : (sk_v || rv);
      if (load && (sk_v || rv)) {m_tdata, m_tkeep, m_tuser, m_tlast} <= sk_v ? sk : {ram_q, rl};
      if (rv && (!load || sk_v)) sk <= {ram_q, rl};
      if (pop && m_tlast) begin
        dsc_rd      <= dsc_rd + DPW'(1);
        cnt_pkt_out <= cnt_pkt_out + 32'd1;
      end
    end

`ifdef PCIE_RX_PKT_BUF_LAT_EN
  logic [31:0] now, pkt_start, first_cyc, lat;
  logic [31:0] dsc_start [PKT_DEPTH];

  assign first_cyc = (beat_cnt == '0) ? now : pkt_start;
  assign lat       = now - dsc_start[dsc_rd[DW-1:0]];

  always_ff @(posedge RX_clk or posedge RX_rst)
    if (RX_rst) begin
      now       <= '0;
      pkt_start <= '0;
      lat_last  <= '0;
      lat_max   <= '0;
    end else begin
      now <= now + 32'd1;
      if (wr_en && beat_cnt == '0) pkt_start <= now;
      if (pop && m_tlast) begin
        lat_last <= lat;
        if (lat > lat_max) lat_max <= lat;
      end
    end

  always_ff @(posedge RX_clk)
    if (commit) dsc_start[dsc_wr[DW-1:0]] <= first_cyc;
`endif
endmodule

// File: tb/tb_pcie_rx_pkt_buffer.sv
// tb_pcie_rx_pkt_buffer: scoreboard bench for pcie_rx_pkt_buffer (latency checks under PCIE_RX_PKT_BUF_LAT_EN).
module tb_pcie_rx_pkt_buffer;
  localparam int DATA_W = 256, KEEP_W = 32, USER_W = 64;
  localparam int DEPTH = 512, PKT_DEPTH = 32, MAX_BEATS = 64;
  localparam int EW = DATA_W + KEEP_W + USER_W + 1;

  logic              RX_clk = 1'b0, RX_rst = 1'b1;
  logic [DATA_W-1:0] s_tdata = '0;
  logic [KEEP_W-1:0] s_tkeep = '0;
  logic [USER_W-1:0] s_tuser = '0;
  logic              s_tvalid = 1'b0, s_tlast = 1'b0, m_tready = 1'b1;
  logic              s_tready, m_tvalid, m_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic [USER_W-1:0] m_tuser;
  logic [31:0]       cnt_pkt_in, cnt_pkt_out, cnt_pkt_drop;
`ifdef PCIE_RX_PKT_BUF_LAT_EN
  logic [31:0]       lat_last, lat_max;
`endif

  pcie_rx_pkt_buffer dut (
    .RX_clk(RX_clk), .RX_rst(RX_rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
    .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .cnt_pkt_in(cnt_pkt_in), .cnt_pkt_out(cnt_pkt_out), .cnt_pkt_drop(cnt_pkt_drop)
`ifdef PCIE_RX_PKT_BUF_LAT_EN
    , .lat_last(lat_last), .lat_max(lat_max)
`endif
  );

  int n_chk = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];
  int start_q[$];
  int used = 0, pkts = 0, exp_in = 0, exp_out = 0, exp_drop = 0;
  int lat_exp = 0, lat_max_exp = 0;
  int cyc = 0;
  bit rdy_chk = 1'b0;

  always #2 RX_clk = ~RX_clk;
  always @(posedge RX_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge RX_clk) begin : mon
    logic [EW-1:0] e;
    if (!RX_rst) begin
      if (rdy_chk && !s_tready) chk("s_tready", s_tready, 1'b1);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("spurious_beat", m_tvalid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {m_tdata, m_tkeep, m_tuser, m_tlast}, e);
          used--;
          if (e[0]) begin
            pkts--;
            exp_out++;
            if (start_q.size() != 0) begin
              lat_exp = cyc + 1 - start_q.pop_front();
              if (lat_exp > lat_max_exp) lat_max_exp = lat_exp;
            end
          end
        end
      end
    end
  end

  task automatic send(input int n);
    logic [EW-1:0] beats[$];
    bit drop;
    int start;
    drop = n > MAX_BEATS || used + n > DEPTH || pkts == PKT_DEPTH;
    start = cyc + 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < DATA_W / 32; k++) s_tdata[k*32 +: 32] = $urandom;
      s_tkeep  = (i == 1) ? '0 : KEEP_W'($urandom);
      s_tuser  = {$urandom, $urandom};
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      beats.push_back({s_tdata, s_tkeep, s_tuser, s_tlast});
      @(posedge RX_clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (drop) exp_drop++;
    else begin
      exp_in++;
      used += n;
      pkts++;
      start_q.push_back(start);
      foreach (beats[i]) exp_q.push_back(beats[i]);
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || m_tvalid) && t < 3000) begin
      @(negedge RX_clk);
      t++;
    end
    chk(tag, t < 3000, 1'b1);
    @(posedge RX_clk); #1;
  endtask

  task automatic chk_cnt();
    chk("cnt_pkt_in", cnt_pkt_in, exp_in);
    chk("cnt_pkt_out", cnt_pkt_out, exp_out);
    chk("cnt_pkt_drop", cnt_pkt_drop, exp_drop);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge RX_clk);
    #1 RX_rst = 1'b0;
    @(posedge RX_clk); #1;
    rdy_chk = 1'b1;
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_m_out", {m_tdata, m_tkeep, m_tuser, m_tlast}, '0);
    chk("rst_s_tready", s_tready, 1'b1);
    chk_cnt();
`ifdef PCIE_RX_PKT_BUF_LAT_EN
    chk("rst_lat_last", lat_last, 32'd0);
    chk("rst_lat_max", lat_max, 32'd0);
`endif
    // 3-beat packet: valid rises exactly two cycles after the tlast handshake
    send(3);
    @(negedge RX_clk) chk("t1_valid_c0", m_tvalid, 1'b0);
    @(negedge RX_clk) chk("t1_valid_c1", m_tvalid, 1'b0);
    @(negedge RX_clk) chk("t1_valid_c2", m_tvalid, 1'b1);
    drain("t1_drain");
    chk_cnt();
    // oversized packet dropped whole, following packet intact
    send(65);
    send(2);
    drain("t2_drain");
    chk_cnt();
    // descriptor FIFO overflow
    m_tready = 1'b0;
    repeat (33) send(1);
    chk_cnt();
    repeat (3) @(posedge RX_clk); #1;
    chk("t3_stall_hold", {m_tdata, m_tkeep, m_tuser, m_tlast}, exp_q[0]);
    m_tready = 1'b1;
    drain("t3_drain");
    chk_cnt();
    // data RAM fills exactly, ninth packet dropped, tenth accepted after drain
    m_tready = 1'b0;
    repeat (9) send(64);
    chk_cnt();
    chk("t4_stall_valid", m_tvalid, 1'b1);
    chk("t4_stall_hold", {m_tdata, m_tkeep, m_tuser, m_tlast}, exp_q[0]);
    m_tready = 1'b1;
    drain("t4_drain_a");
    send(64);
    drain("t4_drain_b");
    chk_cnt();
    // reset mid-packet with two packets stored
    m_tready = 1'b0;
    send(1);
    send(1);
    for (int i = 0; i < 2; i++) begin
      s_tdata = {8{32'hdead_beef}};
      s_tvalid = 1'b1;
      @(posedge RX_clk); #1;
    end
    s_tvalid = 1'b0;
    rdy_chk = 1'b0;
    RX_rst = 1'b1;
    #1;
    chk("t5_async_valid", m_tvalid, 1'b0);
    exp_q.delete();
    start_q.delete();
    used = 0; pkts = 0; exp_in = 0; exp_out = 0; exp_drop = 0;
    lat_exp = 0; lat_max_exp = 0;
    chk_cnt();
    repeat (2) @(posedge RX_clk);
    #1 RX_rst = 1'b0;
    @(posedge RX_clk); #1;
    rdy_chk = 1'b1;
    chk("t5_s_tready", s_tready, 1'b1);
    m_tready = 1'b1;
    send(1);
    drain("t5_drain");
    chk_cnt();
`ifdef PCIE_RX_PKT_BUF_LAT_EN
    chk("t5_lat_last", lat_last, lat_exp);
    send(4);
    drain("t6_drain_a");
    chk("t6_lat_last", lat_last, lat_exp);
    send(2);
    drain("t6_drain_b");
    chk("t6_lat_last2", lat_last, lat_exp);
    chk("t6_lat_max", lat_max, lat_max_exp);
    chk_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
